// File: rtl/instr_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_loader_pkg : shared types and constants for the loader          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package instr_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

   localparam int BYTES_PER_WORD = 4;

endpackage : instr_loader_pkg
`default_nettype wire

// File: rtl/instr_loader_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_packer : little-endian byte-to-word assembly buffer             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module byte_packer
   import instr_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  load,
   input  logic [BYTE_WIDTH-1:0] byte_data,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_full
);

   logic [1:0]            idx;
   logic [DATA_WIDTH-1:0] buffer;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         idx    <= 2'd0;
         buffer <= '0;
      end else if (load) begin
         buffer[int'(idx)*BYTE_WIDTH +: BYTE_WIDTH] <= byte_data;
         idx <= idx + 2'd1;
      end
   end

   assign word      = buffer;
   // Flags the load that fills the final slot, so the FSM can leave RECV on that same edge.
   assign word_full = load && (idx == 2'(BYTES_PER_WORD - 1));

endmodule : byte_packer
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_loader : packs a byte stream into instruction-memory writes,   |
// | stalling the CPU until the image is loaded.                           |
// | Optional checksum output: define INSTR_LOADER_CHECKSUM_EN.            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int BYTE_WIDTH    = 8
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     byte_valid,
   input  logic [BYTE_WIDTH-1:0]    byte_data,
   input  logic                     byte_last,
   output logic                     byte_ready,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     cpu_hold,
   output logic                     done,
   output logic                     error,
   output logic [ADDRESS_WIDTH-2:0] words_written
`ifdef INSTR_LOADER_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0]    checksum
`endif
);

   localparam logic [ADDRESS_WIDTH-1:0] TOP_WORD_ADDR = ~(ADDRESS_WIDTH'(BYTES_PER_WORD - 1));
   localparam logic [ADDRESS_WIDTH-1:0] WORD_STEP     = ADDRESS_WIDTH'(BYTES_PER_WORD);

   loader_state_t state;
   logic          last_seen;
   logic          accept;
   logic          word_full;
   logic          start_load;
   logic          back_to_recv;
   logic          packer_clear;

   assign accept       = byte_ready && byte_valid;
   assign start_load   = start && ((state == IDLE) || (state == DONE));
   assign back_to_recv = (state == WRITE) && !last_seen && (mem_addr != TOP_WORD_ADDR);
   assign packer_clear = start_load || back_to_recv;

   byte_packer #(
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH)
   ) u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (packer_clear),
      .load      (accept),
      .byte_data (byte_data),
      .word      (mem_wdata),
      .word_full (word_full)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         byte_ready    <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         cpu_hold      <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         words_written <= '0;
         last_seen     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state         <= RECV;
                  byte_ready    <= 1'b1;
                  cpu_hold      <= 1'b1;
                  done          <= 1'b0;
                  error         <= 1'b0;
                  mem_addr      <= '0;
                  words_written <= '0;
                  last_seen     <= 1'b0;
               end
            end
            RECV: begin
               if (accept && (byte_last || word_full)) begin
                  state      <= WRITE;
                  byte_ready <= 1'b0;
                  mem_we     <= 1'b1;
                  last_seen  <= byte_last;
               end
            end
            WRITE: begin
               mem_we        <= 1'b0;
               mem_addr      <= mem_addr + WORD_STEP;
               words_written <= words_written + 1'b1;
               if (last_seen) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
               end else if (mem_addr == TOP_WORD_ADDR) begin
                  // Image larger than memory: stop and refuse the rest of the stream.
                  state    <= DONE;
                  done     <= 1'b1;
                  error    <= 1'b1;
                  cpu_hold <= 1'b0;
               end else begin
                  state      <= RECV;
                  byte_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef INSTR_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!rst_n || start_load) begin
         checksum <= '0;
      end else if (state == WRITE) begin
         checksum <= checksum + mem_wdata;
      end
   end
`endif

endmodule : instr_loader
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_loader : directed self-checking bench for instr_loader      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_instr_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_last;
   logic        byte_ready;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [6:0]  words_written;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   int passes = 0;
   int total  = 0;

   logic [7:0]  wa[$];
   logic [31:0] wd[$];

   always #5 clk = ~clk;

   instr_loader #(
      .ADDRESS_WIDTH (8),
      .DATA_WIDTH    (32),
      .BYTE_WIDTH    (8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_last     (byte_last),
      .byte_ready    (byte_ready),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .cpu_hold      (cpu_hold),
      .done          (done),
      .error         (error),
      .words_written (words_written)
`ifdef INSTR_LOADER_CHECKSUM_EN
      ,
      .checksum      (checksum)
`endif
   );

   // Write log of everything the DUT puts on the memory port.
   always @(posedge clk) begin
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      int n = 0;
      @(negedge clk);
      byte_valid = 1'b1; byte_data = d; byte_last = l;
      while (!byte_ready && n < 20) begin
         @(negedge clk); n++;
      end
      check("accept_timeout", 32'(byte_ready), 32'd1);
      @(posedge clk); #1;
      byte_valid = 1'b0; byte_last = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 100) begin
         @(negedge clk); n++;
      end
      check(tag, 32'(done), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(byte_ready), 32'd0);
      check({tag, "_we"},    32'(mem_we), 32'd0);
      check({tag, "_addr"},  32'(mem_addr), 32'd0);
      check({tag, "_wdata"}, mem_wdata, 32'd0);
      check({tag, "_hold"},  32'(cpu_hold), 32'd0);
      check({tag, "_done"},  32'(done), 32'd0);
      check({tag, "_error"}, 32'(error), 32'd0);
      check({tag, "_words"}, 32'(words_written), 32'd0);
   endtask

   initial begin
      logic [7:0] img8 [8];
      logic [7:0] img5 [5];
      int         ready_seen;
      img8 = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
      img5 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

      rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset");
`ifdef INSTR_LOADER_CHECKSUM_EN
      check("reset_checksum", checksum, 32'd0);
`endif

      // Stream presented before any start must be refused.
      byte_valid = 1'b1; byte_data = 8'h55;
      repeat (3) @(negedge clk);
      check("nostart_ready", 32'(byte_ready), 32'd0);
      check("nostart_writes", 32'(wa.size()), 32'd0);
      byte_valid = 1'b0;

      // Back-to-back 8-byte image.
      pulse_start();
      check("start_hold", 32'(cpu_hold), 32'd1);
      check("start_ready", 32'(byte_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         send_byte(img8[i], 1'(i == 7));
         if (i == 3) begin
            check("lat_we", 32'(mem_we), 32'd1);
            check("lat_addr", 32'(mem_addr), 32'h00);
            check("lat_wdata", mem_wdata, 32'h00500513);
         end
      end
      wait_done("img8_done");
      check("img8_nwrites", 32'(wa.size()), 32'd2);
      check("img8_a0", 32'(wa[0]), 32'h00);
      check("img8_d0", wd[0], 32'h00500513);
      check("img8_a1", 32'(wa[1]), 32'h04);
      check("img8_d1", wd[1], 32'h00100593);
      check("img8_hold", 32'(cpu_hold), 32'd0);
      check("img8_words", 32'(words_written), 32'd2);
      check("img8_error", 32'(error), 32'd0);
      check("img8_ready", 32'(byte_ready), 32'd0);
`ifdef INSTR_LOADER_CHECKSUM_EN
      @(negedge clk);
      check("img8_checksum", checksum, 32'h00600AA6);
`endif

      // 5-byte image: partial final word padded with zeros.
      wa.delete(); wd.delete();
      pulse_start();
      check("img5_done_cleared", 32'(done), 32'd0);
      for (int i = 0; i < 5; i++) send_byte(img5[i], 1'(i == 4));
      wait_done("img5_done");
      check("img5_nwrites", 32'(wa.size()), 32'd2);
      check("img5_a0", 32'(wa[0]), 32'h00);
      check("img5_d0", wd[0], 32'hDDCCBBAA);
      check("img5_a1", 32'(wa[1]), 32'h04);
      check("img5_d1", wd[1], 32'h000000EE);
      check("img5_error", 32'(error), 32'd0);

      // Gapped stream with a stray start pulse during RECV.
      wa.delete(); wd.delete();
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (i == 2) begin
            pulse_start();
            check("midstart_hold", 32'(cpu_hold), 32'd1);
            check("midstart_ready", 32'(byte_ready), 32'd1);
         end
         send_byte(img8[i], 1'(i == 7));
      end
      wait_done("gap_done");
      check("gap_nwrites", 32'(wa.size()), 32'd2);
      check("gap_a0", 32'(wa[0]), 32'h00);
      check("gap_d0", wd[0], 32'h00500513);
      check("gap_a1", 32'(wa[1]), 32'h04);
      check("gap_d1", wd[1], 32'h00100593);
      check("gap_words", 32'(words_written), 32'd2);

      // Overflow: 256 bytes fill memory, the remainder is refused.
      wa.delete(); wd.delete();
      pulse_start();
      for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b0);
      wait_done("ovf_done");
      check("ovf_error", 32'(error), 32'd1);
      check("ovf_nwrites", 32'(wa.size()), 32'd64);
      check("ovf_d_first", wd[0], 32'h03020100);
      check("ovf_a_last", 32'(wa[63]), 32'hFC);
      check("ovf_d_last", wd[63], 32'hFFFEFDFC);
      check("ovf_words", 32'(words_written), 32'd64);
      ready_seen = 0;
      @(negedge clk); byte_valid = 1'b1; byte_data = 8'h77;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (byte_ready) ready_seen++;
      end
      byte_valid = 1'b0;
      check("ovf_refuse", 32'(ready_seen), 32'd0);
      check("ovf_nwrites_after", 32'(wa.size()), 32'd64);

      // Reset partway through the second word.
      wa.delete(); wd.delete();
      pulse_start();
      for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 1'b0);
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      check("midrst_nwrites", 32'(wa.size()), 32'd1);
      check("midrst_d0", wd[0], 32'h04030201);
      wa.delete(); wd.delete();
      pulse_start();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b1);
      wait_done("reload_done");
      check("reload_nwrites", 32'(wa.size()), 32'd1);
      check("reload_a0", 32'(wa[0]), 32'h00);
      check("reload_d0", wd[0], 32'h44332211);
      check("reload_words", 32'(words_written), 32'd1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule : tb_instr_loader
`default_nettype wire
